// File: rtl/obstacle_motion_ctrl.sv
// Multi-lane obstacle position counters with a saturating game timer and level ramp.
// Registered outputs; advancement only on RUN-state ticks, clear has top priority.
module obstacle_motion_ctrl #(
  parameter int NUM_LANES    = 4,
  parameter int POS_W        = 10,
  parameter int TIME_W       = 11,
  parameter int WRAP_LIMIT   = 680,
  parameter int BASE_STEP    = 5,
  parameter int LANE_SPACING = 160,
  parameter int LEVEL_TICKS  = 600,
  parameter int MAX_LEVEL    = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         menu_screen,
  input  logic                         player_won,
  input  logic                         player_lost,
  input  logic                         pause,
  input  logic [NUM_LANES-1:0]         lane_restart,
  output logic [NUM_LANES*POS_W-1:0]   obj_pos,
  output logic [NUM_LANES-1:0]         lane_wrap,
  output logic [TIME_W-1:0]            game_time,
  output logic [2:0]                   level,
  output logic                         level_up,
  output logic [1:0]                   run_state
);

  localparam int LVL_W = 3;
  localparam int TMR_W = $clog2(LEVEL_TICKS);

  localparam logic [POS_W-1:0]  WRAP_V    = POS_W'(WRAP_LIMIT);
  localparam logic [POS_W-1:0]  BASE_V    = POS_W'(BASE_STEP);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LEVEL_TICKS - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX_V = LVL_W'(MAX_LEVEL);
  localparam logic [TIME_W-1:0] TIME_MAX  = '1;

  // The largest sum ever formed must fit in a lane counter, and every stagger start must lie below the wrap point.
  if (WRAP_LIMIT - 1 + BASE_STEP + MAX_LEVEL >= (1 << POS_W)) begin : g_bad_pos_w
    $error("obstacle_motion_ctrl: POS_W too small for WRAP_LIMIT + max step");
  end
  if ((NUM_LANES - 1) * LANE_SPACING >= WRAP_LIMIT) begin : g_bad_spacing
    $error("obstacle_motion_ctrl: lane stagger exceeds WRAP_LIMIT");
  end
  if (MAX_LEVEL > 7) begin : g_bad_level
    $error("obstacle_motion_ctrl: MAX_LEVEL must fit in 3 bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t                 r_state;
  logic [POS_W-1:0]       r_pos [NUM_LANES];
  logic [NUM_LANES-1:0]   r_wrap;
  logic [TIME_W-1:0]      r_game_time;
  logic [LVL_W-1:0]       r_level;
  logic [TMR_W-1:0]       r_lvl_tmr;
  logic                   r_level_up;

  logic                   w_clear;
  logic [POS_W-1:0]       w_step;

  assign w_clear = menu_screen | player_won | player_lost;
  assign w_step  = BASE_V + {{(POS_W-LVL_W){1'b0}}, r_level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < NUM_LANES; i++) r_pos[i] <= POS_W'(i * LANE_SPACING);
      r_wrap      <= '0;
      r_game_time <= '0;
      r_level     <= '0;
      r_lvl_tmr   <= '0;
      r_level_up  <= 1'b0;
    end else begin
      r_wrap     <= '0;
      r_level_up <= 1'b0;
      if (w_clear) begin
        r_state     <= ST_IDLE;
        for (int i = 0; i < NUM_LANES; i++) r_pos[i] <= POS_W'(i * LANE_SPACING);
        r_game_time <= '0;
        r_level     <= '0;
        r_lvl_tmr   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (tick && !pause) r_state <= ST_RUN;
          ST_RUN: begin
            // Pause wins over a coincident tick: the tick is dropped, not deferred.
            if (pause) begin
              r_state <= ST_PAUSED;
            end else if (tick) begin
              for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_restart[i]) begin
                  r_pos[i] <= POS_W'(i * LANE_SPACING);
                end else if (r_pos[i] >= WRAP_V) begin
                  r_pos[i]  <= POS_W'(i * LANE_SPACING);
                  r_wrap[i] <= 1'b1;
                end else begin
                  r_pos[i] <= r_pos[i] + w_step;
                end
              end
              if (r_game_time != TIME_MAX) r_game_time <= r_game_time + 1'b1;
              if (r_lvl_tmr == TMR_LAST) begin
                r_lvl_tmr <= '0;
                if (r_level < LVL_MAX_V) begin
                  r_level    <= r_level + 1'b1;
                  r_level_up <= 1'b1;
                end
              end else begin
                r_lvl_tmr <= r_lvl_tmr + 1'b1;
              end
            end
          end
          ST_PAUSED: if (!pause) r_state <= ST_RUN;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign obj_pos[g*POS_W +: POS_W] = r_pos[g];
  end

  assign lane_wrap = r_wrap;
  assign game_time = r_game_time;
  assign level     = r_level;
  assign level_up  = r_level_up;
  assign run_state = r_state;

endmodule
